// File: rtl/muldiv_pkg.sv
// Shared definitions for the MULT/DIV sequencer: FSM state encoding,
// operation codes and the default wait-timeout length.
package muldiv_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT,
        WRITEBACK,
        ERROR
    } seqState_e;

    localparam logic [1:0] OP_MULT = 2'b00;
    localparam logic [1:0] OP_DIV  = 2'b01;

    localparam int DEFAULT_TIMEOUT_CYCLES = 64;
    localparam int CNT_W = 7;

endpackage

// File: rtl/muldiv_sequencer.sv
// Sequences one MULT or DIV operation at a time: issues a start pulse,
// waits for the selected unit, then commits HI/LO or raises an exception.
module muldiv_sequencer
    import muldiv_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       req_valid,
    input  logic [1:0] req_op,
    input  logic       abort,
    input  logic       mult_done,
    input  logic       div_done,
    input  logic       div_by_zero,
    output logic       req_ready,
    output logic       mult_start,
    output logic       div_start,
    output logic       hi_sel,
    output logic       lo_sel,
    output logic       hi_we,
    output logic       lo_we,
    output logic       done,
    output logic       err_divzero,
    output logic       err_timeout,
    output logic       busy
);

    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    seqState_e        state, stateNext;
    logic             opIsDiv, opIsDivNext;
    logic             errIsDivZero, errIsDivZeroNext;
    logic [CNT_W-1:0] waitCnt, waitCntNext;
    logic             unitDone;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state        <= IDLE;
            opIsDiv      <= 1'b0;
            errIsDivZero <= 1'b0;
            waitCnt      <= '0;
        end else begin
            state        <= stateNext;
            opIsDiv      <= opIsDivNext;
            errIsDivZero <= errIsDivZeroNext;
            waitCnt      <= waitCntNext;
        end
    end

    always_comb begin
        stateNext        = state;
        opIsDivNext      = opIsDiv;
        errIsDivZeroNext = errIsDivZero;
        waitCntNext      = waitCnt;
        unitDone         = opIsDiv ? div_done : mult_done;

        case (state)
            IDLE: begin
                if (req_valid && !abort && (req_op == OP_MULT || req_op == OP_DIV)) begin
                    stateNext   = ISSUE;
                    opIsDivNext = (req_op == OP_DIV);
                end
            end
            ISSUE: begin
                waitCntNext = '0;
                stateNext   = WAIT;
            end
            WAIT: begin
                waitCntNext = waitCnt + 1'b1;
                // Divide-by-zero beats completion, completion beats timeout.
                if (opIsDiv && div_by_zero) begin
                    stateNext        = ERROR;
                    errIsDivZeroNext = 1'b1;
                end else if (unitDone) begin
                    stateNext = WRITEBACK;
                end else if (waitCnt == TIMEOUT_LAST) begin
                    stateNext        = ERROR;
                    errIsDivZeroNext = 1'b0;
                end
            end
            WRITEBACK: stateNext = IDLE;
            ERROR:     stateNext = IDLE;
            default:   stateNext = IDLE;
        endcase

        if (abort && state != IDLE) begin
            stateNext = IDLE;
        end

        // Moore outputs: decoded from registered state and latched op only.
        req_ready   = (state == IDLE);
        busy        = (state != IDLE);
        mult_start  = (state == ISSUE) && !opIsDiv;
        div_start   = (state == ISSUE) && opIsDiv;
        hi_sel      = opIsDiv;
        lo_sel      = opIsDiv;
        hi_we       = (state == WRITEBACK);
        lo_we       = (state == WRITEBACK);
        done        = (state == WRITEBACK);
        err_divzero = (state == ERROR) && errIsDivZero;
        err_timeout = (state == ERROR) && !errIsDivZero;
    end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed bench for muldiv_sequencer: a default-timeout instance (A) and a
// TIMEOUT_CYCLES=8 instance (B) share all inputs.
module tb_muldiv_sequencer;
    import muldiv_pkg::*;

    logic       clock = 1'b0;
    logic       reset;
    logic       req_valid, abort, mult_done, div_done, div_by_zero;
    logic [1:0] req_op;

    logic readyA, multStartA, divStartA, hiSelA, loSelA, hiWeA, loWeA;
    logic doneA, errDzA, errToA, busyA;
    logic readyB, multStartB, divStartB, hiSelB, loSelB, hiWeB, loWeB;
    logic doneB, errDzB, errToB, busyB;

    int checks = 0;
    int failures = 0;
    logic seen;

    muldiv_sequencer dutA (
        .clock(clock), .reset(reset), .req_valid(req_valid), .req_op(req_op),
        .abort(abort), .mult_done(mult_done), .div_done(div_done),
        .div_by_zero(div_by_zero), .req_ready(readyA), .mult_start(multStartA),
        .div_start(divStartA), .hi_sel(hiSelA), .lo_sel(loSelA), .hi_we(hiWeA),
        .lo_we(loWeA), .done(doneA), .err_divzero(errDzA), .err_timeout(errToA),
        .busy(busyA)
    );

    muldiv_sequencer #(.TIMEOUT_CYCLES(8)) dutB (
        .clock(clock), .reset(reset), .req_valid(req_valid), .req_op(req_op),
        .abort(abort), .mult_done(mult_done), .div_done(div_done),
        .div_by_zero(div_by_zero), .req_ready(readyB), .mult_start(multStartB),
        .div_start(divStartB), .hi_sel(hiSelB), .lo_sel(loSelB), .hi_we(hiWeB),
        .lo_we(loWeB), .done(doneB), .err_divzero(errDzB), .err_timeout(errToB),
        .busy(busyB)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic observed, input logic expected);
        checks++;
        assert (observed === expected)
        else begin
            failures++;
            $error("FAIL %s observed=%b expected=%b", tag, observed, expected);
        end
    endtask

    task automatic doReset();
        reset = 1'b0;
        #3;
        reset = 1'b1;
        tick();
    endtask

    initial begin
        reset = 1'b1; req_valid = 1'b0; req_op = OP_MULT; abort = 1'b0;
        mult_done = 1'b0; div_done = 1'b0; div_by_zero = 1'b0;
        #1 reset = 1'b0;
        #10;
        check("rst_ready", readyA, 1'b1);
        check("rst_busy", busyA, 1'b0);
        check("rst_mult_start", multStartA, 1'b0);
        check("rst_div_start", divStartA, 1'b0);
        check("rst_hi_sel", hiSelA, 1'b0);
        check("rst_lo_sel", loSelA, 1'b0);
        check("rst_we", hiWeA | loWeA, 1'b0);
        check("rst_done", doneA, 1'b0);
        check("rst_err", errDzA | errToA, 1'b0);
        reset = 1'b1;
        tick();

        // MULT completing after 33 WAIT cycles: done at cycle 35
        req_valid = 1'b1; req_op = OP_MULT;
        tick();
        req_valid = 1'b0;
        check("mult_start_c1", multStartA, 1'b1);
        check("mult_no_div_start", divStartA, 1'b0);
        check("mult_busy", busyA, 1'b1);
        check("mult_not_ready", readyA, 1'b0);
        seen = 1'b0;
        for (int c = 2; c <= 34; c++) begin
            tick();
            seen = seen | doneA | multStartA | hiWeA;
        end
        check("mult_early_activity", seen, 1'b0);
        mult_done = 1'b1;
        tick();
        mult_done = 1'b0;
        check("mult_done_c35", doneA, 1'b1);
        check("mult_hi_we", hiWeA, 1'b1);
        check("mult_lo_we", loWeA, 1'b1);
        check("mult_hi_sel", hiSelA, 1'b0);
        check("mult_lo_sel", loSelA, 1'b0);
        tick();
        check("mult_back_idle", readyA, 1'b1);
        check("mult_done_single", doneA, 1'b0);

        // DIV with div_by_zero and div_done in the 3rd WAIT cycle
        req_valid = 1'b1; req_op = OP_DIV;
        tick();
        req_valid = 1'b0;
        check("div_start", divStartA, 1'b1);
        check("div_no_mult_start", multStartA, 1'b0);
        check("div_hi_sel", hiSelA, 1'b1);
        tick(); tick(); tick();
        div_by_zero = 1'b1; div_done = 1'b1;
        tick();
        div_by_zero = 1'b0; div_done = 1'b0;
        check("dz_err_divzero", errDzA, 1'b1);
        check("dz_err_timeout", errToA, 1'b0);
        check("dz_no_write", hiWeA | loWeA, 1'b0);
        check("dz_no_done", doneA, 1'b0);
        tick();
        check("dz_idle", readyA, 1'b1);
        check("dz_pulse_single", errDzA, 1'b0);
        check("dz_hi_sel_held", hiSelA, 1'b1);

        // abort together with mult_done, then a normal DIV
        req_valid = 1'b1; req_op = OP_MULT;
        tick();
        req_valid = 1'b0;
        tick();
        abort = 1'b1; mult_done = 1'b1;
        tick();
        abort = 1'b0; mult_done = 1'b0;
        check("abort_idle", readyA, 1'b1);
        check("abort_no_done", doneA, 1'b0);
        check("abort_no_write", hiWeA | loWeA, 1'b0);
        check("abort_no_err", errDzA | errToA, 1'b0);
        tick();
        check("abort_no_late_done", doneA, 1'b0);
        req_valid = 1'b1; req_op = OP_DIV;
        tick();
        req_valid = 1'b0;
        check("post_abort_div_start", divStartA, 1'b1);
        tick();
        mult_done = 1'b1;
        tick();
        mult_done = 1'b0;
        check("div_ignores_mult_done", busyA & ~doneA, 1'b1);
        div_done = 1'b1;
        tick();
        div_done = 1'b0;
        check("post_abort_div_done", doneA, 1'b1);
        check("post_abort_div_sel", loSelA, 1'b1);
        tick();

        // reserved op, abort in IDLE, and requests while busy
        req_valid = 1'b1; req_op = 2'b11;
        tick();
        check("reserved_stays_idle", readyA, 1'b1);
        check("reserved_no_start", multStartA | divStartA, 1'b0);
        req_op = OP_MULT; abort = 1'b1;
        tick();
        check("abort_idle_blocks_req", readyA, 1'b1);
        abort = 1'b0;
        tick();
        check("held_req_accepted", multStartA, 1'b1);
        req_op = OP_DIV;
        seen = 1'b0;
        for (int c = 0; c < 3; c++) begin
            tick();
            seen = seen | multStartA | divStartA | readyA;
        end
        check("busy_req_ignored", seen, 1'b0);
        req_valid = 1'b0; mult_done = 1'b1;
        tick();
        mult_done = 1'b0;
        check("busy_req_mult_done", doneA, 1'b1);
        check("busy_req_sel_mult", hiSelA, 1'b0);
        tick();

        // TIMEOUT_CYCLES=8: err_timeout exactly 10 cycles after acceptance
        doReset();
        req_valid = 1'b1; req_op = OP_DIV;
        tick();
        req_valid = 1'b0;
        seen = 1'b0;
        for (int c = 2; c <= 9; c++) begin
            tick();
            seen = seen | errToB | ~busyB;
        end
        check("to_not_early", seen, 1'b0);
        tick();
        check("to_err_timeout_c10", errToB, 1'b1);
        check("to_no_divzero", errDzB, 1'b0);
        check("to_no_done", doneB, 1'b0);
        tick();
        check("to_ready_after", readyB, 1'b1);
        check("to_pulse_single", errToB, 1'b0);

        // completion in the timeout cycle wins
        req_valid = 1'b1; req_op = OP_DIV;
        tick();
        req_valid = 1'b0;
        for (int c = 2; c <= 9; c++) tick();
        div_done = 1'b1;
        tick();
        div_done = 1'b0;
        check("to_edge_done", doneB, 1'b1);
        check("to_edge_no_err", errToB, 1'b0);
        tick();
        doReset();

        // asynchronous reset mid-WAIT
        req_valid = 1'b1; req_op = OP_DIV;
        tick();
        req_valid = 1'b0;
        tick(); tick();
        check("pre_rst_busy", busyA, 1'b1);
        #2 reset = 1'b0;
        #1;
        check("async_rst_ready", readyA, 1'b1);
        check("async_rst_busy", busyA, 1'b0);
        check("async_rst_hi_sel", hiSelA, 1'b0);
        #2 reset = 1'b1;
        mult_done = 1'b1; div_done = 1'b1;
        tick();
        check("post_rst_no_done", doneA, 1'b0);
        check("post_rst_no_write", hiWeA | loWeA, 1'b0);
        check("post_rst_idle", busyA, 1'b0);
        mult_done = 1'b0; div_done = 1'b0;
        tick();
        check("post_rst_still_no_done", doneA, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/muldiv_sequencer.md
MULDIV_SEQUENCER -- requirements
Module: muldiv_sequencer

Interface
REQ-001 Parameter: TIMEOUT_CYCLES, default 64, maximum WAIT cycles before abort (range 2..127).
REQ-002 clock  in  1  single clock; all state updates on the rising edge.
REQ-003 reset  in  1  asynchronous, active-low; asserted (0) forces reset state immediately.
REQ-004 req_valid  in  1  control unit requests a MULT/DIV operation.
REQ-005 req_op  in  2  operation: 00 MULT, 01 DIV, 10/11 reserved.
REQ-006 abort  in  1  control-unit flush; cancels any in-flight operation.
REQ-007 mult_done  in  1  multiplier completion strobe.
REQ-008 div_done  in  1  divider completion strobe.
REQ-009 div_by_zero  in  1  divider zero-divisor flag.
REQ-010 req_ready  out  1  sequencer accepts a request this cycle.
REQ-011 mult_start, div_start  out  1 each  one-cycle start pulses to the multiplier and divider.
REQ-012 hi_sel, lo_sel  out  1 each  HI/LO source mux selects: 0 multiplier, 1 divider.
REQ-013 hi_we, lo_we  out  1 each  HI/LO register write enables.
REQ-014 done  out  1  one-cycle pulse: result committed.
REQ-015 err_divzero, err_timeout  out  1 each  one-cycle exception pulses to the control unit.
REQ-016 busy  out  1  operation in flight.

Function
REQ-017 States: IDLE, ISSUE, WAIT, WRITEBACK, ERROR. All outputs are decoded from registered state/op only (Moore).
REQ-018 req_ready = 1 only in IDLE; busy = 1 in every state except IDLE.
REQ-019 IDLE: req_valid=1 with req_op 00/01 latches the op and goes to ISSUE next cycle. Reserved ops are ignored and the sequencer stays in IDLE.
REQ-020 ISSUE, exactly one cycle: mult_start=1 for MULT or div_start=1 for DIV; clears the wait counter; next state WAIT.
REQ-021 WAIT: the counter increments every cycle. The done input of the latched unit goes to WRITEBACK. The done input of the non-selected unit is ignored.
REQ-022 WAIT, DIV only: div_by_zero=1 goes to ERROR with err_divzero. This takes priority over div_done in the same cycle.
REQ-023 WAIT: counter == TIMEOUT_CYCLES-1 without completion goes to ERROR with err_timeout. A completion in that same cycle takes priority over the timeout.
REQ-024 WRITEBACK, exactly one cycle: hi_we=lo_we=1 and done=1; next state IDLE.
REQ-025 ERROR, exactly one cycle: the latched exception pulse is asserted; hi_we=lo_we=0; next state IDLE.
REQ-026 hi_sel and lo_sel equal the latched op bit from ISSUE through WRITEBACK and hold their last value in IDLE.
REQ-027 Latency from request acceptance to done: 2 + N cycles, where N is the number of WAIT cycles up to and including the unit's done cycle.
REQ-028 abort=1 in any non-IDLE state returns to IDLE next cycle with no write, no done and no error pulse. abort wins over every simultaneous event.
REQ-029 abort in IDLE has no effect. A req_valid in the same cycle as abort in IDLE is not accepted.
REQ-030 req_valid while busy is ignored (no queueing). The control unit must hold req_valid until req_ready.
REQ-031 Each start pulse is asserted at most once per accepted request.

Reset
REQ-032 On reset=0: state IDLE, counter 0, latched op MULT, all pulses/enables 0, hi_sel=lo_sel=0, req_ready=1, busy=0.
REQ-033 Reset asserted mid-operation discards the operation; no write or pulse is produced on release.

Structure
REQ-034 Shared package muldiv_pkg holds the state enum, the op encoding constants (OP_MULT, OP_DIV) and the default TIMEOUT_CYCLES.
REQ-035 No sub-module; the 7-bit wait counter and the FSM live in one module.

Verification
REQ-036 MULT: req_op=00 in IDLE; mult_done after 33 WAIT cycles -> mult_start at cycle 1, hi_we=lo_we=done=1 with hi_sel=lo_sel=0 at cycle 35.
REQ-037 DIV with div_by_zero=1 and div_done=1 in the 3rd WAIT cycle -> err_divzero pulse, no hi_we/lo_we, no done, back to IDLE.
REQ-038 TIMEOUT_CYCLES=8, DIV with no done -> err_timeout exactly 10 cycles after acceptance, then req_ready=1.
REQ-039 abort in the same cycle as mult_done -> no done, no write, IDLE next cycle; a new DIV request is then accepted normally.
REQ-040 req_op=11 in IDLE, and req_valid during WAIT -> no start pulses and no state change for the extra requests.
REQ-041 reset=0 asserted asynchronously mid-WAIT -> outputs reach reset values immediately; mult_done after release is ignored.
